// File: rtl/tri_pkg.sv
// Shared types for the triangle raster front end (scan generator and the
// point-in-triangle test stage).
package tri_pkg;

  localparam int COORD_W = 9;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {IDLE, SETUP, SCAN} scan_state_t;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/tri_bbox.sv
// Combinational bounding box of three vertices. With TRI_RASTER_CLIP_EN
// defined, the box maxima are clamped to the screen and 'off' flags a box
// that lies entirely outside it; otherwise 'off' is always 0.
module tri_bbox
  import tri_pkg::*;
#(
  parameter int SCR_W = 320,
  parameter int SCR_H = 240
) (
  input  coord_t ax,
  input  coord_t ay,
  input  coord_t bx,
  input  coord_t by,
  input  coord_t cx,
  input  coord_t cy,
  output coord_t xmin,
  output coord_t xmax,
  output coord_t ymin,
  output coord_t ymax,
  output logic   off
);

  coord_t xlo, xhi, ylo, yhi;

  // Unclipped box: unsigned min/max over the three vertices.
  always_comb begin
    xlo = min3(ax, bx, cx);
    xhi = max3(ax, bx, cx);
    ylo = min3(ay, by, cy);
    yhi = max3(ay, by, cy);
  end

  assign xmin = xlo;
  assign ymin = ylo;

`ifdef TRI_RASTER_CLIP_EN
  localparam coord_t XLIM = coord_t'(SCR_W - 1);
  localparam coord_t YLIM = coord_t'(SCR_H - 1);

  // Only the maxima can leave the screen; minima are unsigned and >= 0.
  assign xmax = (xhi > XLIM) ? XLIM : xhi;
  assign ymax = (yhi > YLIM) ? YLIM : yhi;
  assign off  = (xlo > xmax) || (ylo > ymax);
`else
  assign xmax = xhi;
  assign ymax = yhi;
  assign off  = 1'b0;

  // Screen size only matters when clipping is built in.
  logic unused_scr;
  assign unused_scr = ^{SCR_W, SCR_H};
`endif

endmodule

// File: rtl/tri_raster_scan.sv
// Triangle bounding-box scan generator. On start, latches three vertices,
// computes their bounding box in SETUP, then streams every pixel of the box
// column-major (py inner, px outer) over a valid/ready handshake, flagging the
// final pixel with pix_last and pulsing done afterwards.
// Optional screen clipping: define TRI_RASTER_CLIP_EN.
// COORD_W must match tri_pkg::COORD_W (the box logic uses tri_pkg::coord_t).
module tri_raster_scan
  import tri_pkg::coord_t;
  import tri_pkg::scan_state_t;
  import tri_pkg::IDLE;
  import tri_pkg::SETUP;
  import tri_pkg::SCAN;
#(
  parameter int COORD_W = 9,
  parameter int SCR_W   = 320,
  parameter int SCR_H   = 240
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic               busy,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last,
  output logic               done
);

  scan_state_t state, state_nxt;
  coord_t      la_x, la_y, lb_x, lb_y, lc_x, lc_y;
  coord_t      xmin, xmax, ymin, ymax;
  coord_t      bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic        bb_off;
  logic        hs, done_nxt;

  tri_bbox #(.SCR_W(SCR_W), .SCR_H(SCR_H)) u_bbox (
    .ax(la_x), .ay(la_y), .bx(lb_x), .by(lb_y), .cx(lc_x), .cy(lc_y),
    .xmin(bb_xmin), .xmax(bb_xmax), .ymin(bb_ymin), .ymax(bb_ymax),
    .off(bb_off)
  );

  assign pix_valid = (state == SCAN);
  assign busy      = (state != IDLE);
  assign hs        = pix_valid && pix_ready;
  // Gated by pix_valid so the reset-zeroed box does not flag a phantom last.
  assign pix_last  = pix_valid && (px == xmax) && (py == ymax);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and done-pulse decode.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SETUP;
      SETUP: begin
        state_nxt = bb_off ? IDLE : SCAN;
        done_nxt  = bb_off;
      end
      SCAN:  if (hs && pix_last) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vertex latch, box registers and the px/py walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      {la_x, la_y, lb_x, lb_y, lc_x, lc_y} <= '0;
      {xmin, xmax, ymin, ymax}             <= '0;
      px   <= '0;
      py   <= '0;
      done <= 1'b0;
    end else begin
      done <= done_nxt;
      if (state == IDLE && start) begin
        la_x <= ax; la_y <= ay;
        lb_x <= bx; lb_y <= by;
        lc_x <= cx; lc_y <= cy;
      end
      if (state == SETUP) begin
        xmin <= bb_xmin; xmax <= bb_xmax;
        ymin <= bb_ymin; ymax <= bb_ymax;
        if (!bb_off) begin
          px <= bb_xmin;
          py <= bb_ymin;
        end
      end
      // Increments only while strictly below the max, so no wrap is possible.
      if (state == SCAN && hs) begin
        if (py < ymax) begin
          py <= py + coord_t'(1);
        end else if (px < xmax) begin
          px <= px + coord_t'(1);
          py <= ymin;
        end
      end
    end
  end

endmodule

// File: tb/tb_tri_raster_scan.sv
// Directed bench for tri_raster_scan: table of triangles with hand-computed
// boxes and pixel counts, plus sequences for backpressure, mid-scan reset and
// ignored mid-scan start. Build with TRI_RASTER_CLIP_EN for the clipped table.
module tb_tri_raster_scan;

`ifdef TRI_RASTER_CLIP_EN
  localparam int SW = 8;
  localparam int SH = 10;
`else
  localparam int SW = 320;
  localparam int SH = 240;
`endif

  logic       clk, rst, start, pix_ready;
  logic [8:0] ax, ay, bx, by, cx, cy, px, py;
  logic       busy, pix_valid, pix_last, done;

  tri_raster_scan #(.COORD_W(9), .SCR_W(SW), .SCR_H(SH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .busy(busy), .px(px), .py(py), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int ax, ay, bx, by, cx, cy;
    int xmin, xmax, ymin, ymax;
    int npix;   // 0 means the box is entirely off-screen
  } vec_t;

  vec_t tbl[6];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, what, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vtx(input vec_t v);
    ax = 9'(v.ax); ay = 9'(v.ay);
    bx = 9'(v.bx); by = 9'(v.by);
    cx = 9'(v.cx); cy = 9'(v.cy);
  endtask

  // Issue start, check latency, then walk the stream against the expected box.
  // poke_at >= 0 pulses start (with other vertices) at that pixel index.
  task automatic run_scan(input vec_t v, input int poke_at);
    int k, h, cyc;
    set_vtx(v);
    start = 1'b1;
    step();
    start = 1'b0;
    chk(v.nm, "busy_c1", busy, 1);
    chk(v.nm, "valid_c1", pix_valid, 0);
    step();
    if (v.npix == 0) begin
      chk(v.nm, "off_done_c2", done, 1);
      chk(v.nm, "off_valid_c2", pix_valid, 0);
      chk(v.nm, "off_busy_c2", busy, 0);
      step();
      chk(v.nm, "off_done_width", done, 0);
      return;
    end
    chk(v.nm, "valid_c2", pix_valid, 1);
    h = v.ymax - v.ymin + 1;
    k = 0;
    cyc = 0;
    while (pix_valid && cyc < 2000) begin
      chk(v.nm, "pixel_xy", 32'({px, py}),
          32'(((v.xmin + k / h) << 9) | (v.ymin + k % h)));
      chk(v.nm, "pix_last", pix_last, (k == v.npix - 1) ? 1 : 0);
      chk(v.nm, "busy_done_in_scan", {busy, done}, 2'b10);
      if (k == poke_at) begin
        start = 1'b1;
        ax = 9'd0; ay = 9'd0; bx = 9'd1; by = 9'd1; cx = 9'd2; cy = 9'd0;
      end else begin
        start = 1'b0;
      end
      k++;
      cyc++;
      step();
    end
    start = 1'b0;
    chk(v.nm, "timeout", (cyc < 2000) ? 1 : 0, 1);
    chk(v.nm, "pixel_count", k, v.npix);
    chk(v.nm, "done_after_last", done, 1);
    chk(v.nm, "busy_after_last", busy, 0);
    chk(v.nm, "px_hold_idle", px, v.xmax);
    chk(v.nm, "py_hold_idle", py, v.ymax);
    step();
    chk(v.nm, "done_width", done, 0);
  endtask

  initial begin
    int k, cyc;
    bit stalled, prev57;

`ifdef TRI_RASTER_CLIP_EN
    tbl[0] = '{"tri",     3, 3,  6, 12,  9, 8,  3, 7,  3, 9,  35};
    tbl[1] = '{"degen",   2, 2,  2,  2,  2, 2,  2, 2,  2, 2,   1};
    tbl[2] = '{"vert",    5, 2,  5,  9,  5, 4,  5, 5,  2, 9,   8};
    tbl[3] = '{"horiz",   1, 7,  4,  7,  2, 7,  1, 4,  7, 7,   4};
    tbl[4] = '{"offscr",  8, 1, 12,  3,  9, 2,  0, 0,  0, 0,   0};
    tbl[5] = '{"corner",  6, 8, 20, 30,  7, 9,  6, 7,  8, 9,   4};
`else
    tbl[0] = '{"tri",       3,   3,   6,  12,   9,   8,   3,   9,   3,  12, 70};
    tbl[1] = '{"degen",    10,  10,  10,  10,  10,  10,  10,  10,  10,  10,  1};
    tbl[2] = '{"vert",      5,   2,   5,   9,   5,   4,   5,   5,   2,   9,  8};
    tbl[3] = '{"horiz",     1,   7,   4,   7,   2,   7,   1,   4,   7,   7,  4};
    tbl[4] = '{"maxcoord",511, 510, 510, 511, 511, 511, 510, 511, 510, 511,  4};
    tbl[5] = '{"origin",    0,   0,   2,   1,   1,   0,   0,   2,   0,   1,  6};
`endif

    // Reset state, with start held to show reset dominates it.
    rst = 1'b1; start = 1'b1; pix_ready = 1'b1;
    set_vtx(tbl[0]);
    repeat (3) step();
    chk("reset", "px", px, 0);
    chk("reset", "py", py, 0);
    chk("reset", "pix_valid", pix_valid, 0);
    chk("reset", "pix_last", pix_last, 0);
    chk("reset", "busy", busy, 0);
    chk("reset", "done", done, 0);
    rst = 1'b0; start = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_scan(tbl[i], -1);

    // Start pulsed mid-scan must not disturb the sequence.
    run_scan(tbl[0], 10);

    // Backpressure: hold ready low for 3 cycles at (5,7).
    set_vtx(tbl[0]);
    start = 1'b1; step(); start = 1'b0; step();
    k = 0; cyc = 0; stalled = 0; prev57 = 0;
    while (pix_valid && cyc < 2000) begin
      if (px == 9'd5 && py == 9'd7 && !stalled) begin
        pix_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          chk("bp", "stall_xy", 32'({px, py}), (5 << 9) | 7);
          chk("bp", "stall_valid", pix_valid, 1);
        end
        pix_ready = 1'b1;
        stalled = 1;
      end
      if (prev57) chk("bp", "after_release", 32'({px, py}), (5 << 9) | 8);
      prev57 = (px == 9'd5 && py == 9'd7);
      chk("bp", "pixel_xy", 32'({px, py}),
          32'(((3 + k / (tbl[0].ymax - 2)) << 9) | (3 + k % (tbl[0].ymax - 2))));
      k++;
      cyc++;
      step();
    end
    chk("bp", "stalled_seen", stalled, 1);
    chk("bp", "pixel_count", k, tbl[0].npix);
    chk("bp", "done", done, 1);
    step();

    // Reset after 20 handshakes: stream stops, no done pulse.
    set_vtx(tbl[0]);
    start = 1'b1; step(); start = 1'b0; step();
    repeat (20) step();
    chk("rst_mid", "valid_before", pix_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid", "pix_valid", pix_valid, 0);
    chk("rst_mid", "busy", busy, 0);
    chk("rst_mid", "done", done, 0);
    step();
    chk("rst_mid", "done_later", done, 0);
    chk("rst_mid", "idle_busy", busy, 0);

    // Restart rescans from the beginning.
    run_scan(tbl[0], -1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
